// File: rtl/ofm_pad_writer.sv
// Walks the zero-padded layer-2 IFM frame (tile, row, col) and writes zero words for border pixels or live OFM groups for interior ones.
// Interior writes are strobed combinationally on ofm_valid; border writes are one per cycle.
module ofm_pad_writer #(
  parameter int ADDR_W  = 32,
  parameter int MAX_PAD = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        OFM_W,
  input  logic [7:0]        OFM_C,
  input  logic [1:0]        pad,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              ofm_valid,
  output logic              ofm_ready,
  output logic              wr_rd_req_IFM_layer_2,
  output logic [ADDR_W-1:0] wr_addr_IFM_layer_2,
  output logic              write_padding,
  output logic              busy,
  output logic              done,
  output logic              err_overrun
);

  typedef enum logic [1:0] {S_IDLE, S_PAD, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        w_q, w_d;
  logic [1:0]        pad_q, pad_d;
  logic [8:0]        pw_q, pw_d;
  logic [4:0]        tiles_q, tiles_d;
  logic [4:0]        t_q, t_d;
  logic [8:0]        r_q, r_d;
  logic [8:0]        c_q, c_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  logic [1:0] pad_eff;
  logic [8:0] pw_in;
  logic [4:0] tiles_in;
  logic       step, c_wrap, r_wrap, last;
  logic [8:0] c_nx, r_nx;
  logic [4:0] t_nx;

  function automatic logic in_band(input logic [8:0] x, input logic [1:0] p, input logic [7:0] w);
    return (x >= {7'd0, p}) && (x < ({7'd0, p} + {1'b0, w}));
  endfunction

  // Out-of-range pad requests are clamped to the widest supported border.
  assign pad_eff  = (32'(pad) > MAX_PAD) ? 2'(MAX_PAD) : pad;
  assign pw_in    = {1'b0, OFM_W} + {6'd0, pad_eff, 1'b0};
  assign tiles_in = 5'(({1'b0, OFM_C} + 9'd15) >> 4);

  assign ofm_ready             = (state_q == S_WAIT);
  assign write_padding         = (state_q == S_WAIT) && ofm_valid;
  assign step                  = (state_q == S_PAD) || write_padding;
  assign wr_rd_req_IFM_layer_2 = step;
  assign wr_addr_IFM_layer_2   = addr_q;
  assign busy                  = (state_q == S_PAD) || (state_q == S_WAIT);
  assign done                  = (state_q == S_DONE);
  assign err_overrun           = err_q;

  assign c_wrap = (c_q == pw_q - 9'd1);
  assign r_wrap = (r_q == pw_q - 9'd1);
  assign last   = c_wrap && r_wrap && (t_q == tiles_q - 5'd1);
  assign c_nx   = c_wrap ? 9'd0 : c_q + 9'd1;
  assign r_nx   = c_wrap ? (r_wrap ? 9'd0 : r_q + 9'd1) : r_q;
  assign t_nx   = (c_wrap && r_wrap) ? t_q + 5'd1 : t_q;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    pad_d   = pad_q;
    pw_d    = pw_q;
    tiles_d = tiles_q;
    t_d     = t_q;
    r_d     = r_q;
    c_d     = c_q;
    addr_d  = addr_q;
    err_d   = err_q | (ofm_valid & ~ofm_ready);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_d     = OFM_W;
          pad_d   = pad_eff;
          pw_d    = pw_in;
          tiles_d = tiles_in;
          t_d     = 5'd0;
          r_d     = 9'd0;
          c_d     = 9'd0;
          addr_d  = base_addr;
          err_d   = ofm_valid;
          if (OFM_W == 8'd0 || OFM_C == 8'd0) state_d = S_DONE;
          else if (pad_eff == 2'd0)           state_d = S_WAIT;
          else                                state_d = S_PAD;
        end
      end
      S_PAD, S_WAIT: begin
        if (step) begin
          c_d    = c_nx;
          r_d    = r_nx;
          t_d    = t_nx;
          addr_d = addr_q + ADDR_W'(1);
          if (last)                                                     state_d = S_DONE;
          else if (in_band(r_nx, pad_q, w_q) && in_band(c_nx, pad_q, w_q)) state_d = S_WAIT;
          else                                                          state_d = S_PAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      pad_q   <= '0;
      pw_q    <= '0;
      tiles_q <= '0;
      t_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      pad_q   <= pad_d;
      pw_q    <= pw_d;
      tiles_q <= tiles_d;
      t_q     <= t_d;
      r_q     <= r_d;
      c_q     <= c_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ofm_pad_writer.sv
// Bench for ofm_pad_writer: a word-index model of the padded frame predicts every cycle's
// strobe, address, data select, ready, busy, done and overrun flag under random ofm_valid.
module tb_ofm_pad_writer;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        OFM_W;
  logic [7:0]        OFM_C;
  logic [1:0]        pad;
  logic [ADDR_W-1:0] base_addr;
  logic              ofm_valid;
  logic              ofm_ready;
  logic              wr_rd_req_IFM_layer_2;
  logic [ADDR_W-1:0] wr_addr_IFM_layer_2;
  logic              write_padding;
  logic              busy;
  logic              done;
  logic              err_overrun;

  int n_checks = 0;
  int n_errors = 0;
  bit err_exp  = 1'b0;

  ofm_pad_writer #(.ADDR_W(ADDR_W), .MAX_PAD(2)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .OFM_W                 (OFM_W),
    .OFM_C                 (OFM_C),
    .pad                   (pad),
    .base_addr             (base_addr),
    .ofm_valid             (ofm_valid),
    .ofm_ready             (ofm_ready),
    .wr_rd_req_IFM_layer_2 (wr_rd_req_IFM_layer_2),
    .wr_addr_IFM_layer_2   (wr_addr_IFM_layer_2),
    .write_padding         (write_padding),
    .busy                  (busy),
    .done                  (done),
    .err_overrun           (err_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr"},    wr_rd_req_IFM_layer_2, 0);
    check({tag, "_addr"},  wr_addr_IFM_layer_2,   0);
    check({tag, "_wpad"},  write_padding,         0);
    check({tag, "_ready"}, ofm_ready,             0);
    check({tag, "_busy"},  busy,                  0);
    check({tag, "_done"},  done,                  0);
    check({tag, "_err"},   err_overrun,           0);
  endtask

  // Runs one frame. Word k of the frame is pixel (k / PW^2, (k % PW^2) / PW, k % PW) at base+k.
  task automatic run_frame(input int w, input int ch, input int p, input logic [31:0] base,
                           input int vld_pct, input bit inject, input int abort_at);
    int pw, tiles, n, k, pos, rr, cc;
    bit inner, drive;
    pw    = w + 2 * p;
    tiles = (ch + 15) / 16;
    n     = (w == 0 || ch == 0) ? 0 : tiles * pw * pw;
    k     = 0;

    @(negedge clk);
    OFM_W     = 8'(w);
    OFM_C     = 8'(ch);
    pad       = 2'(p);
    base_addr = base;
    ofm_valid = 1'b0;
    start     = 1'b1;
    #1;
    check("idle_wr", wr_rd_req_IFM_layer_2, 0);
    @(negedge clk);
    start   = 1'b0;
    err_exp = 1'b0;
    // Scramble config inputs: the frame must run on the latched copy.
    OFM_W     = 8'($urandom);
    OFM_C     = 8'($urandom);
    pad       = 2'($urandom_range(2));
    base_addr = $urandom;

    while (k < n) begin
      pos   = k % (pw * pw);
      rr    = pos / pw;
      cc    = pos % pw;
      inner = (rr >= p) && (rr < p + w) && (cc >= p) && (cc < p + w);
      if (k == abort_at) begin
        ofm_valid = 1'b0;
        start     = 1'b0;
        reset     = 1'b0;
        #1;
        check_idle_outputs("abort");
        #2;
        reset   = 1'b1;
        err_exp = 1'b0;
        return;
      end
      drive     = inner ? ($urandom_range(99) < vld_pct) : (inject && k == 2);
      ofm_valid = drive;
      start     = ($urandom_range(7) == 0);
      #1;
      check("busy", busy, 1);
      check("done_early", done, 0);
      check("ready", ofm_ready, 32'(inner));
      check("err", err_overrun, 32'(err_exp));
      if (!inner || drive) begin
        check("wr", wr_rd_req_IFM_layer_2, 1);
        check("addr", wr_addr_IFM_layer_2, base + 32'(k));
        check("wpad", write_padding, 32'(inner));
        k++;
      end else begin
        check("stall_wr", wr_rd_req_IFM_layer_2, 0);
      end
      if (drive && !inner) err_exp = 1'b1;
      @(negedge clk);
    end

    ofm_valid = 1'b0;
    start     = 1'b0;
    #1;
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    check("wr_at_done", wr_rd_req_IFM_layer_2, 0);
    check("err_at_done", err_overrun, 32'(err_exp));
    @(negedge clk);
    #1;
    check("done_low", done, 0);
    check("err_after", err_overrun, 32'(err_exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, ch, p, pct;
    logic [31:0] base;
    reset     = 1'b0;
    start     = 1'b0;
    OFM_W     = '0;
    OFM_C     = '0;
    pad       = '0;
    base_addr = '0;
    ofm_valid = 1'b0;
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    run_frame(2, 16, 1, 32'h100, 50, 1'b0, -1);
    run_frame(3, 32, 0, 32'h0, 100, 1'b0, -1);
    run_frame(1, 17, 2, 32'h0, 60, 1'b0, -1);
    run_frame(2, 16, 1, 32'h100, 70, 1'b1, -1);
    run_frame(2, 16, 1, 32'h100, 100, 1'b0, -1);
    run_frame(4, 0, 1, 32'h40, 100, 1'b0, -1);
    run_frame(0, 16, 2, 32'h40, 100, 1'b0, -1);
    run_frame(2, 16, 1, 32'h100, 100, 1'b0, 5);
    run_frame(2, 16, 1, 32'h100, 100, 1'b0, -1);
    run_frame(3, 8, 1, 32'hFFFF_FFF8, 80, 1'b0, -1);

    for (int i = 0; i < 14; i++) begin
      w    = $urandom_range(5);
      ch   = $urandom_range(40);
      p    = $urandom_range(2);
      pct  = $urandom_range(30, 100);
      base = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : 32'($urandom_range(4095));
      run_frame(w, ch, p, base, pct, 1'($urandom_range(1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
